// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a synchronous FIFO.
// A granted producer keeps the port until its last beat so packets never interleave.
module fifo_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16,
  parameter int PTR_W  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fullreg,
  output logic                   wr_en,
  output logic [DATA_W-1:0]      din,
  output logic [PTR_W-1:0]       owner,
  output logic                   locked,
  output logic [15:0]            stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PTR_W-1:0]   rr_ptr_r;
  logic [PTR_W-1:0]   rr_ptr_nxt_s;
  logic [PTR_W-1:0]   owner_r;
  logic [PTR_W-1:0]   owner_nxt_s;
  logic [15:0]        stall_cnt_r;

  logic               found_s;
  logic               hit_s;
  logic [PTR_W-1:0]   win_s;
  logic [PTR_W-1:0]   sel_s;
  logic [PTR_W-1:0]   sel_inc_s;
  logic               grant_s;
  logic               sel_valid_s;
  logic               sel_last_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               xfer_s;
  logic               stall_s;

  // Winner search: lowest valid index at or above rr_ptr first, then wrap to the lowest below it.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    win_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      hit_s   = ~found_s & req_valid[i] & (PTR_W'(i) >= rr_ptr_r);
      win_s   = hit_s ? PTR_W'(i) : win_s;
      found_s = found_s | hit_s;
    end
    for (int i = 0; i < NREQ; i++) begin
      hit_s   = ~found_s & req_valid[i] & (PTR_W'(i) < rr_ptr_r);
      win_s   = hit_s ? PTR_W'(i) : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Selected producer: search winner while idle, the locked owner otherwise.
  always_comb begin
    sel_s       = (state_r == LOCK) ? owner_r : win_s;
    grant_s     = (state_r == LOCK) | found_s;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_valid_s = (PTR_W'(i) == sel_s) ? req_valid[i] : sel_valid_s;
      sel_last_s  = (PTR_W'(i) == sel_s) ? req_last[i] : sel_last_s;
      sel_data_s  = (PTR_W'(i) == sel_s) ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
    end
    xfer_s    = ~reset & sel_valid_s & ~fullreg;
    stall_s   = sel_valid_s & fullreg;
    sel_inc_s = (sel_s == PTR_W'(NREQ-1)) ? '0 : sel_s + PTR_W'(1);
  end

  // FIFO-facing handshake; everything is held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = ~reset & grant_s & ~fullreg & (PTR_W'(i) == sel_s);
    end
    wr_en = xfer_s;
    din   = xfer_s ? sel_data_s : '0;
  end

  // Next-state logic: lock on a non-last beat, release and advance the pointer on a last beat.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    owner_nxt_s  = owner_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          owner_nxt_s = sel_s;
          if (sel_last_s) begin
            rr_ptr_nxt_s = sel_inc_s;
          end else begin
            state_nxt_s = LOCK;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCK: begin
        if (xfer_s && sel_last_s) begin
          state_nxt_s  = IDLE;
          rr_ptr_nxt_s = sel_inc_s;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      owner_r  <= '0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      owner_r  <= owner_nxt_s;
    end
  end

  // Saturating count of cycles the selected producer was blocked by a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign owner     = owner_r;
  assign locked    = (state_r == LOCK);
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: constant vector table, hand-written corner sequences,
// then randomized traffic checked against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fullreg;
  logic        wr_en;
  logic [15:0] din;
  logic [1:0]  owner;
  logic        locked;
  logic [15:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  fifo_wr_arbiter #(.NREQ(4), .DATA_W(16), .PTR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fullreg   (fullreg),
    .wr_en     (wr_en),
    .din       (din),
    .owner     (owner),
    .locked    (locked),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [63:0] d;
    logic        f;
    logic        ewr;
    logic [15:0] edin;
    logic [3:0]  erdy;
    logic [1:0]  eown;
    logic        elck;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [63:0] d, input logic f);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    fullreg   = f;
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [63:0] d, input logic f,
                     input logic ewr, input logic [15:0] edin, input logic [3:0] erdy,
                     input logic [1:0] eown, input logic elck);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.f = f;
    r.ewr = ewr; r.edin = edin; r.erdy = erdy; r.eown = eown; r.elck = elck;
    tbl.push_back(r);
  endtask

  logic [63:0] rr_d;
  logic [63:0] p1_d;

  initial begin
    rr_d = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 64'h0, 1'b0);
    #50 reset = 1'b0;
    @(posedge clk); #1;

    // reset state
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;

    // single-beat round robin, packet lock, pointer wrap, idle
    for (int k = 0; k < 8; k++)
      add(4'b1111, 4'b1111, rr_d, 1'b0, 1'b1, 16'hA000 + 16'(k % 4), 4'(4'b0001 << (k % 4)), 2'(k % 4), 1'b0);
    add(4'b0110, 4'b0100, {16'h0, 16'hC002, 16'hB941, 16'h0}, 1'b0, 1'b1, 16'hB941, 4'b0010, 2'd1, 1'b1);
    add(4'b0110, 4'b0100, {16'h0, 16'hC002, 16'hB942, 16'h0}, 1'b0, 1'b1, 16'hB942, 4'b0010, 2'd1, 1'b1);
    add(4'b0110, 4'b0110, {16'h0, 16'hC002, 16'hB943, 16'h0}, 1'b0, 1'b1, 16'hB943, 4'b0010, 2'd1, 1'b0);
    add(4'b0100, 4'b0100, {16'h0, 16'hC002, 16'h0, 16'h0}, 1'b0, 1'b1, 16'hC002, 4'b0100, 2'd2, 1'b0);
    add(4'b1001, 4'b1001, rr_d, 1'b0, 1'b1, 16'hA003, 4'b1000, 2'd3, 1'b0);
    add(4'b1001, 4'b1001, rr_d, 1'b0, 1'b1, 16'hA000, 4'b0001, 2'd0, 1'b0);
    add(4'b1001, 4'b1001, rr_d, 1'b0, 1'b1, 16'hA003, 4'b1000, 2'd3, 1'b0);
    add(4'b1001, 4'b1001, rr_d, 1'b0, 1'b1, 16'hA000, 4'b0001, 2'd0, 1'b0);
    add(4'b0000, 4'b0000, 64'h0, 1'b0, 1'b0, 16'h0000, 4'b0000, 2'd0, 1'b0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].ewr));
      chk($sformatf("vec%0d_din", i), 32'(din), 32'(tbl[i].edin));
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].erdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(tbl[i].eown));
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].elck));
    end

    // full back-pressure: five stalled cycles, then the held beat goes out once
    drive(4'b0001, 4'b0001, {48'h0, 16'hD000}, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_wr_en", 32'(wr_en), 32'd0);
      chk("full_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("full_stall5", 32'(stall_cnt), 32'd5);
    fullreg = 1'b0;
    @(negedge clk);
    chk("full_release_wr", 32'(wr_en), 32'd1);
    chk("full_release_din", 32'(din), 32'h0000D000);
    chk("full_release_rdy", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    drive(4'b0000, 4'b0000, 64'h0, 1'b0);
    @(negedge clk);
    chk("full_once_wr", 32'(wr_en), 32'd0);
    chk("full_stall_hold", 32'(stall_cnt), 32'd5);
    @(posedge clk); #1;

    // owner bubble: producer 2 packet, drops valid for two cycles while producer 3 waits
    drive(4'b0100, 4'b0000, {16'hF003, 16'hE001, 32'h0}, 1'b0);
    @(negedge clk);
    chk("bub_first_din", 32'(din), 32'h0000E001);
    @(posedge clk); #1;
    chk("bub_locked", 32'(locked), 32'd1);
    chk("bub_owner", 32'(owner), 32'd2);
    for (int k = 0; k < 2; k++) begin
      drive(4'b1000, 4'b1000, {16'hF003, 48'h0}, 1'b0);
      @(negedge clk);
      chk("bub_wr_en", 32'(wr_en), 32'd0);
      chk("bub_ready", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      chk("bub_hold_lock", 32'(locked), 32'd1);
      chk("bub_hold_owner", 32'(owner), 32'd2);
    end
    drive(4'b1100, 4'b1100, {16'hF003, 16'hE002, 32'h0}, 1'b0);
    @(negedge clk);
    chk("bub_resume_din", 32'(din), 32'h0000E002);
    chk("bub_resume_rdy", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    chk("bub_unlock", 32'(locked), 32'd0);
    drive(4'b1000, 4'b1000, {16'hF003, 48'h0}, 1'b0);
    @(negedge clk);
    chk("bub_next_din", 32'(din), 32'h0000F003);
    @(posedge clk); #1;
    chk("bub_next_owner", 32'(owner), 32'd3);

    // reset asserted mid-packet
    p1_d = {32'h0, 16'h1111, 16'h0};
    drive(4'b0010, 4'b0000, p1_d, 1'b0);
    @(posedge clk); #1;
    chk("rstlock_locked", 32'(locked), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstlock_drop", 32'(locked), 32'd0);
    chk("rstlock_wr_en", 32'(wr_en), 32'd0);
    chk("rstlock_ready", 32'(req_ready), 32'd0);
    chk("rstlock_din", 32'(din), 32'd0);
    chk("rstlock_owner", 32'(owner), 32'd0);
    chk("rstlock_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(4'b0000, 4'b0000, 64'h0, 1'b0);

    // randomized traffic against the arbitration model
    begin
      int  mown, mptr, mstall, s, idx;
      bit  mlck, found, sv, ewr;
      logic [3:0]  v, l, erdy;
      logic [63:0] d;
      logic [15:0] edin;
      bit f;
      mown = 0; mptr = 0; mstall = 0; mlck = 1'b0;
      for (int n = 0; n < 400; n++) begin
        v = 4'($urandom);
        l = 4'($urandom);
        d = {$urandom, $urandom};
        f = ($urandom_range(0, 3) == 0);
        drive(v, l, d, f);
        @(negedge clk);
        found = 1'b0;
        s = mown;
        if (mlck) begin
          sv = v[mown];
        end else begin
          for (int k = 0; k < 4; k++) begin
            idx = (mptr + k) % 4;
            if (!found && v[idx]) begin
              found = 1'b1;
              s = idx;
            end
          end
          sv = found;
        end
        ewr  = sv && !f;
        erdy = ((mlck || found) && !f) ? 4'(4'b0001 << s) : 4'b0000;
        edin = ewr ? d[s*16 +: 16] : 16'h0000;
        chk("rnd_wr_en", 32'(wr_en), 32'(ewr));
        chk("rnd_din", 32'(din), 32'(edin));
        chk("rnd_ready", 32'(req_ready), 32'(erdy));
        chk("rnd_owner", 32'(owner), 32'(mown));
        chk("rnd_locked", 32'(locked), 32'(mlck));
        chk("rnd_stall", 32'(stall_cnt), 32'(mstall));
        @(posedge clk); #1;
        if (ewr) begin
          mown = s;
          if (l[s]) begin
            mlck = 1'b0;
            mptr = (s + 1) % 4;
          end else begin
            mlck = 1'b1;
          end
        end
        if (f && sv && mstall < 65535) mstall++;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
